// File: rtl/somador_pkg.sv
// somador_pkg: shared FSM state type and default width for the serial adder
package somador_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} estado_t;
  localparam int N_BITS_DEF = 8;
endpackage

// File: rtl/somador_completo.sv
// somador_completo: 1-bit full adder cell
module somador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/somador_serial.sv
// somador_serial: bit-serial two's-complement adder/subtractor, one bit per clock
module somador_serial
  import somador_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sub,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] total,
  output logic              negativo,
  output logic              zero,
  output logic              par,
  output logic              overflow
);
  localparam int CW = $clog2(N_BITS);
  estado_t estado;
  logic [N_BITS-1:0] a, b, res, res_next;
  logic [CW-1:0] cnt;
  logic carry, s, cout, ultimo, carrega;
  somador_completo fa (.a(a[0]), .b(b[0]), .cin(carry), .s(s), .cout(cout));
  assign res_next = {s, res[N_BITS-1:1]};
  assign ultimo   = cnt == CW'(N_BITS - 1);
  assign carrega  = start && estado != BUSY;
  assign busy     = estado == BUSY;
  assign done     = estado == DONE;
  assign negativo = total[N_BITS-1];
  assign zero     = total == '0;
  assign par      = ~total[0];
  // subtraction is A + ~B + 1, the +1 entering as the initial carry
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado   <= IDLE;
      a        <= '0;
      b        <= '0;
      res      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      total    <= '0;
      overflow <= 1'b0;
    end else if (carrega) begin
      a      <= num1;
      b      <= sub ? ~num2 : num2;
      carry  <= sub;
      cnt    <= '0;
      estado <= BUSY;
    end else if (estado == BUSY) begin
      a     <= a >> 1;
      b     <= b >> 1;
      res   <= res_next;
      carry <= cout;
      cnt   <= cnt + 1'b1;
      if (ultimo) begin
        total    <= res_next;
        overflow <= carry ^ cout;
        estado   <= DONE;
      end
    end else begin
      estado <= IDLE;
    end
endmodule

// File: doc/somador_serial.md
# somador_serial

Parametrised bit-serial adder/subtractor with registered result and status flags. It is the sequential successor of the team's combinational 8-bit two's-complement adder. It accepts two signed N_BITS operands on a start request and processes one bit per clock through a single full-adder cell. It then publishes the result with negativo/zero/par flags plus a new overflow flag, so a datapath that trades latency for area can use it.

## Interface

- N_BITS, default 8: operand/result width in bits; legal values are 2 or more.

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  operation request; sampled only in IDLE or DONE.
- sub  in  1  0 = num1 + num2, 1 = num1 − num2; sampled with start.
- num1  in  N_BITS  signed operand A, two's complement; sampled with start.
- num2  in  N_BITS  signed operand B, two's complement; sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse; the result and flags are valid from this cycle.
- total  out  N_BITS  signed result, modulo 2^N_BITS; held until the next completion.
- negativo  out  1  total[N_BITS-1].
- zero  out  1  total == 0.
- par  out  1  ~total[0].
- overflow  out  1  signed overflow of the last operation.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE, start=1: load shift registers.
  - A <= num1.
  - B <= sub ? ~num2 : num2.
  - carry <= sub.
  - bit counter <= 0.
  - Go to BUSY.
- IDLE, start=0: stay in IDLE.
- BUSY, each cycle:
  - Full-add A[0], B[0] and carry.
  - Shift the sum bit into the MSB of the partial-result register.
  - Shift A and B right by one.
  - carry <= carry-out.
  - Increment the counter.
- On the cycle with counter == N_BITS-1:
  - total <= completed result; all four flags update from it in the same edge.
  - overflow <= carry into MSB XOR carry out of MSB.
  - Go to DONE.
- DONE: done=1.
  - start=1: reload operands exactly as from IDLE and go to BUSY (back-to-back operation).
  - start=0: return to IDLE.
- start is ignored in BUSY.
- num1, num2 and sub may change freely during BUSY without effect.
- total and the flags never show partial results; they change only at completion or reset.
- Arithmetic wraps modulo 2^N_BITS; overflow is the only indication of wrap.
- Subtraction of the most negative value follows two's-complement rules. Example: −128 − 1 gives 127 with overflow=1.
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0.
  - total = 0, negativo = 0, zero = 1, par = 1, overflow = 0.
  - Internal registers = 0.
- Reset mid-operation aborts the operation: no done pulse, and total returns to 0.

## Timing

- Edge k samples start=1; busy=1 during cycles k+1 … k+N_BITS.
- Edge k+N_BITS registers total and flags; done=1 and busy=0 during cycle k+N_BITS+1.
- Latency from the start edge to valid result is N_BITS+1 cycles. Throughput is one operation per N_BITS+1 cycles when start is held high.
- All outputs are registered; there is no combinational path from the inputs to any output.
- busy and done are never high together.

## Structure

- Package somador_pkg holds:
  - typedef enum logic [1:0] estado_t {IDLE, BUSY, DONE}.
  - Default-width constant N_BITS_DEF = 8.
- Counter width is $clog2(N_BITS).
- One sub-module: somador_completo, a 1-bit full adder (a, b, cin → s, cout) instantiated once. Its cout at the MSB step is kept alongside its cin for overflow detection.

## Test plan

- N_BITS=8, 5 + 3, sub=0:
  - busy high for 8 cycles, then done pulses for 1 cycle.
  - total=8, negativo=0, zero=0, par=1, overflow=0.
- 100 + 50:
  - total=−106 (0x96), negativo=1, par=1, overflow=1.
  - Then −3 + 2: total=−1, negativo=1, par=0, overflow=0.
- sub=1, 7 − 7:
  - total=0, zero=1, par=1, overflow=0.
  - Then −128 − 1: total=127, overflow=1, negativo=0.
- start held high for two operations (10 + 20, then −5 − 5):
  - Done pulses 9 cycles apart; totals 30 then −10.
  - num1/num2 toggled randomly during BUSY do not alter either result.
- reset asserted asynchronously in the 4th BUSY cycle of 60 + 60:
  - Outputs take reset values without waiting for a clock edge; no done pulse.
  - A following 1 + 1 completes normally with total=2.
- N_BITS=16, 32767 + 1:
  - busy for 16 cycles, total=−32768, overflow=1, negativo=1, par=1.
